udp_ts_buf_arbiter: RTL

UDP_TS_BUF_ARBITER -- requirements
Module: udp_ts_buf_arbiter

---
 rtl/udp_ts_buf_pkg.sv | 21 ++
 rtl/udp_ts_buf_arbiter_if.sv | 44 ++++
 rtl/udp_ts_rr_arbiter.sv | 33 +++
 rtl/udp_ts_buf_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/udp_ts_buf_pkg.sv
// Shared state encoding, default parameters and index-width helper for the TS buffer arbiter.
// Latency: n/a; backpressure: n/a.
package udp_ts_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int DEF_CHANNELS      = 4;
    localparam int DEF_POINTER_WIDTH = 2;
    localparam int DEF_ACK_TIMEOUT   = 15;
    localparam int DEF_REL_BURST     = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/udp_ts_buf_arbiter_if.sv
// Channel, pool and status signals of the TS buffer arbiter; master = arbiter, slave = channels/pool.
// Latency: n/a; backpressure: request/ack level handshakes on both sides.
interface udp_ts_buf_arbiter_if #(
    parameter int P_CHANNELS      = 4,
    parameter int P_POINTER_WIDTH = 2
);
    logic [P_CHANNELS-1:0]                 ch_fetch_req;
    logic [P_CHANNELS-1:0]                 ch_fetch_ack;
    logic [P_POINTER_WIDTH-1:0]            ch_pointer;
    logic [P_CHANNELS-1:0]                 ch_release_req;
    logic [P_CHANNELS*P_POINTER_WIDTH-1:0] ch_release_pointer;
    logic [P_CHANNELS-1:0]                 ch_release_ack;

    logic                                  pool_fetch;
    logic                                  pool_fetch_ack;
    logic [P_POINTER_WIDTH-1:0]            pool_pointer;
    logic                                  pool_release;
    logic [P_POINTER_WIDTH-1:0]            pool_release_pointer;
    logic                                  pool_release_ack;
    logic                                  pool_initialised;
    logic                                  pool_low_water;

    logic                                  timeout_flag;
    logic                                  clear_timeout;
    logic                                  busy;

    modport master (
        input  ch_fetch_req, ch_release_req, ch_release_pointer,
        input  pool_fetch_ack, pool_pointer, pool_release_ack, pool_initialised, pool_low_water,
        input  clear_timeout,
        output ch_fetch_ack, ch_pointer, ch_release_ack,
        output pool_fetch, pool_release, pool_release_pointer,
        output timeout_flag, busy
    );

    modport slave (
        output ch_fetch_req, ch_release_req, ch_release_pointer,
        output pool_fetch_ack, pool_pointer, pool_release_ack, pool_initialised, pool_low_water,
        output clear_timeout,
        input  ch_fetch_ack, ch_pointer, ch_release_ack,
        input  pool_fetch, pool_release, pool_release_pointer,
        input  timeout_flag, busy
    );
endinterface

// File: rtl/udp_ts_rr_arbiter.sv
// Round-robin picker: first requester strictly after last_i, wrapping.
// Latency: combinational; backpressure: none.
module udp_ts_rr_arbiter
    import udp_ts_buf_pkg::*;
#(
    parameter  int P_N = 4,
    localparam int IW  = idx_width(P_N)
) (
    input  logic [P_N-1:0] req_i,
    input  logic [IW-1:0]  last_i,
    output logic [IW-1:0]  gnt_idx_o,
    output logic           gnt_vld_o
);

    always_comb begin
        int            c;
        logic [IW-1:0] cand;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        c         = 0;
        cand      = '0;
        for (int k = 1; k <= P_N; k++) begin
            c = int'(last_i) + k;
            if (c >= P_N) c = c - P_N;
            cand = IW'(c);
            if (!gnt_vld_o && req_i[cand]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/udp_ts_buf_arbiter.sv
// Arbitrates per-channel buffer fetch/release requests onto a single-transaction pool port.
// Latency: channel ack one cycle after pool ack; backpressure: requests held until pool acks or times out.
module udp_ts_buf_arbiter
    import udp_ts_buf_pkg::*;
#(
    parameter int P_CHANNELS      = DEF_CHANNELS,
    parameter int P_POINTER_WIDTH = DEF_POINTER_WIDTH,
    parameter int P_ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
    parameter int P_REL_BURST     = DEF_REL_BURST
) (
    input  logic                 payload_clk,
    input  logic                 payload_rst_n,
    udp_ts_buf_arbiter_if.master bus
);

    localparam int IW = idx_width(P_CHANNELS);
    localparam int PW = P_POINTER_WIDTH;
    localparam int TW = $clog2(P_ACK_TIMEOUT + 1);
    localparam int RW = $clog2(P_REL_BURST + 1);

    state_e                state_q;
    logic [IW-1:0]         sel_q;
    logic [IW-1:0]         fptr_q;
    logic [IW-1:0]         rptr_q;
    logic [P_CHANNELS-1:0] ch_fetch_ack_q;
    logic [P_CHANNELS-1:0] ch_release_ack_q;
    logic [PW-1:0]         ch_pointer_q;
    logic [PW-1:0]         pool_release_pointer_q;
    logic                  pool_fetch_q;
    logic                  pool_release_q;
    logic                  to_flag_q;
    logic                  to_flag_d;
    logic [TW-1:0]         to_cnt_q;
    logic [RW-1:0]         rel_run_q;
    logic [RW-1:0]         rel_run_d;

    logic [IW-1:0]         f_idx;
    logic [IW-1:0]         r_idx;
    logic                  f_vld;
    logic                  r_vld;
    logic                  fetch_any;
    logic                  fetch_ok;
    logic                  rel_pick;
    logic                  to_hit;
    logic                  fetch_done;
    logic                  rel_done;
    logic                  to_event;

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] i);
        return (i == IW'(P_CHANNELS - 1)) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [IW-1:0] rr_prev(input logic [IW-1:0] i);
        return (i == '0) ? IW'(P_CHANNELS - 1) : i - 1'b1;
    endfunction

    // The stored pointers name the next channel to favour; the picker wants the one before it.
    udp_ts_rr_arbiter #(.P_N(P_CHANNELS)) u_rr_fetch (
        .req_i     (bus.ch_fetch_req),
        .last_i    (rr_prev(fptr_q)),
        .gnt_idx_o (f_idx),
        .gnt_vld_o (f_vld)
    );

    udp_ts_rr_arbiter #(.P_N(P_CHANNELS)) u_rr_release (
        .req_i     (bus.ch_release_req),
        .last_i    (rr_prev(rptr_q)),
        .gnt_idx_o (r_idx),
        .gnt_vld_o (r_vld)
    );

    assign fetch_any  = |bus.ch_fetch_req;
    assign fetch_ok   = f_vld && !bus.pool_low_water;
    // Burst cap only yields to a fetch that could actually be served.
    assign rel_pick   = r_vld && ((rel_run_q < RW'(P_REL_BURST)) || !fetch_ok);
    assign to_hit     = (to_cnt_q == TW'(P_ACK_TIMEOUT - 1));
    assign fetch_done = (state_q == ST_FETCH) && bus.pool_fetch_ack;
    assign rel_done   = (state_q == ST_RELEASE) && bus.pool_release_ack;
    assign to_event   = to_hit && (((state_q == ST_FETCH) && !bus.pool_fetch_ack) ||
                                   ((state_q == ST_RELEASE) && !bus.pool_release_ack));

    always_comb begin
        rel_run_d = rel_run_q;
        if (!fetch_any || fetch_done) begin
            rel_run_d = '0;
        end else if (rel_done && (rel_run_q < RW'(P_REL_BURST))) begin
            rel_run_d = rel_run_q + 1'b1;
        end
    end

    always_comb begin
        to_flag_d = to_flag_q;
        if (bus.clear_timeout) to_flag_d = 1'b0;
        if (to_event)          to_flag_d = 1'b1;
    end

    always_ff @(posedge payload_clk or negedge payload_rst_n) begin
        if (!payload_rst_n) begin
            state_q                <= ST_IDLE;
            sel_q                  <= '0;
            fptr_q                 <= '0;
            rptr_q                 <= '0;
            ch_fetch_ack_q         <= '0;
            ch_release_ack_q       <= '0;
            ch_pointer_q           <= '0;
            pool_release_pointer_q <= '0;
            pool_fetch_q           <= 1'b0;
            pool_release_q         <= 1'b0;
            to_flag_q              <= 1'b0;
            to_cnt_q               <= '0;
            rel_run_q              <= '0;
        end else begin
            ch_fetch_ack_q   <= '0;
            ch_release_ack_q <= '0;
            to_flag_q        <= to_flag_d;
            rel_run_q        <= rel_run_d;
            case (state_q)
                ST_IDLE: begin
                    to_cnt_q <= '0;
                    if (bus.pool_initialised) begin
                        if (rel_pick) begin
                            sel_q                  <= r_idx;
                            pool_release_pointer_q <= bus.ch_release_pointer[r_idx*PW +: PW];
                            pool_release_q         <= 1'b1;
                            state_q                <= ST_RELEASE;
                        end else if (fetch_ok) begin
                            sel_q        <= f_idx;
                            pool_fetch_q <= 1'b1;
                            state_q      <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (bus.pool_fetch_ack) begin
                        pool_fetch_q          <= 1'b0;
                        ch_pointer_q          <= bus.pool_pointer;
                        ch_fetch_ack_q[sel_q] <= 1'b1;
                        state_q               <= ST_DONE;
                    end else if (to_hit) begin
                        pool_fetch_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (bus.pool_release_ack) begin
                        pool_release_q          <= 1'b0;
                        ch_release_ack_q[sel_q] <= 1'b1;
                        state_q                 <= ST_DONE;
                    end else if (to_hit) begin
                        pool_release_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (|ch_fetch_ack_q) fptr_q <= rr_next(sel_q);
                    else                 rptr_q <= rr_next(sel_q);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ch_fetch_ack         = ch_fetch_ack_q;
    assign bus.ch_release_ack       = ch_release_ack_q;
    assign bus.ch_pointer           = ch_pointer_q;
    assign bus.pool_fetch           = pool_fetch_q;
    assign bus.pool_release         = pool_release_q;
    assign bus.pool_release_pointer = pool_release_pointer_q;
    assign bus.timeout_flag         = to_flag_q;
    assign bus.busy                 = (state_q != ST_IDLE);

endmodule
